// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with programmable thresholds, occupancy count and error pulses.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is a registered 1-cycle read.
module fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic                     rd,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wrop;
    logic [PW-1:0]     rdop;
    logic [CW-1:0]     cnt;
    logic              wr_ok;
    logic              rd_ok;

    // Acceptance is judged on the pre-edge flags, so a write to a full FIFO loses even with a read.
    always_comb begin
        wr_ok = wr & ~full;
        rd_ok = rd & ~empty;
    end

    // Flag decode straight from the count register.
    always_comb begin
        empty        = (cnt == {CW{1'b0}});
        full         = (cnt == CW'(DEPTH));
        almost_empty = (cnt <= CW'(AE_THRESH));
        almost_full  = (cnt >= CW'(AF_THRESH));
        count        = cnt;
    end

    // Storage array; cleared on reset so the read path never exposes X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_ok) begin
            mem[wrop] <= din;
        end
    end

    // Pointers, occupancy and error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrop      <= {PW{1'b0}};
            rdop      <= {PW{1'b0}};
            cnt       <= {CW{1'b0}};
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wrop <= wrop + PW'(1);
            end
            if (rd_ok) begin
                rdop <= rdop + PW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            overflow  <= wr & full;
            underflow <= rd & empty;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head entry is presented directly; a pop only advances rdop.
    always_comb begin
        if (empty) begin
            dout = {DATA_W{1'b0}};
        end else begin
            dout = mem[rdop];
        end
    end
`else
    // Registered read port: holds its value on every non-read cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= {DATA_W{1'b0}};
        end else if (rd_ok) begin
            dout <= mem[rdop];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param (DATA_W=8, DEPTH=16) using a queue scoreboard model.
module tb_fifo_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr  = 1'b0;
    logic       rd  = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       empty, full, almost_empty, almost_full;
    logic [4:0] count;
    logic       overflow, underflow;

    int         n_tests = 0;
    int         n_fail  = 0;

    logic [7:0] sb[$];
    logic [7:0] exp_dout = 8'h00;
    int         m_cnt    = 0;
    logic       exp_ov   = 1'b0;
    logic       exp_un   = 1'b0;
    logic [3:0] m_wp     = 4'd0;
    logic [3:0] m_rp     = 4'd0;

    always #5 clk = ~clk;

    fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)) dut (
        .clk(clk), .rst(rst), .wr(wr), .rd(rd), .din(din), .dout(dout),
        .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    // One clock of stimulus; the model predicts outputs visible just after the edge.
    task automatic drive(input logic w, input logic r, input logic [7:0] d);
        logic wok, rok;
        @(negedge clk);
        wr = w; rd = r; din = d;
        wok    = w && (m_cnt != 16);
        rok    = r && (m_cnt != 0);
        exp_ov = w && (m_cnt == 16);
        exp_un = r && (m_cnt == 0);
        if (rok) begin
            exp_dout = sb.pop_front();
            m_rp     = m_rp + 4'd1;
        end
        if (wok) begin
            sb.push_back(d);
            m_wp = m_wp + 4'd1;
        end
        m_cnt = sb.size();
`ifdef FIFO_FWFT_EN
        exp_dout = (sb.size() != 0) ? sb[0] : 8'h00;
`endif
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0;
    endtask

    task automatic model_clear();
        sb.delete();
        m_cnt = 0; exp_dout = 8'h00; exp_ov = 1'b0; exp_un = 1'b0;
        m_wp = 4'd0; m_rp = 4'd0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (empty !== 1'b1 || full !== 1'b0 || count !== 5'd0 || dout !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_async: empty=%b full=%b count=%0d dout=%h, want 1 0 0 00", empty, full, count, dout);
        end
        n_tests++;
        if (almost_empty !== 1'b1 || almost_full !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: ae=%b af=%b ov=%b un=%b, want 1 0 0 0", almost_empty, almost_full, overflow, underflow);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 8'h10 + i[7:0]);
            n_tests++;
            if (count !== 5'(m_cnt) || full !== (m_cnt == 16) || almost_full !== (m_cnt >= 14) ||
                almost_empty !== (m_cnt <= 2)) begin
                n_fail++;
                $display("FAIL fill[%0d]: count=%0d full=%b af=%b ae=%b, want count=%0d full=%b af=%b ae=%b",
                         i, count, full, almost_full, almost_empty, m_cnt, m_cnt == 16, m_cnt >= 14, m_cnt <= 2);
            end
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            n_tests++;
            if (dout !== exp_dout || count !== 5'(m_cnt)) begin
                n_fail++;
                $display("FAIL drain[%0d]: dout=%h count=%0d, want dout=%h count=%0d", i, dout, count, exp_dout, m_cnt);
            end
        end
        n_tests++;
        if (empty !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_empty: empty=%b, want 1", empty);
        end
    endtask

    task automatic test_overflow_underflow();
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 8'($urandom_range(0, 200)));
        drive(1'b1, 1'b0, 8'hEE);
        n_tests++;
        if (overflow !== exp_ov || overflow !== 1'b1 || count !== 5'd16) begin
            n_fail++;
            $display("FAIL overflow_pulse: ov=%b count=%0d, want ov=1 count=16", overflow, count);
        end
        drive(1'b0, 1'b0, 8'h00);
        n_tests++;
        if (overflow !== 1'b0 || count !== 5'd16) begin
            n_fail++;
            $display("FAIL overflow_clear: ov=%b count=%0d, want ov=0 count=16", overflow, count);
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            n_tests++;
            if (dout !== exp_dout) begin
                n_fail++;
                $display("FAIL intact[%0d]: dout=%h, want %h", i, dout, exp_dout);
            end
        end
        drive(1'b0, 1'b1, 8'h00);
        n_tests++;
        if (underflow !== 1'b1 || exp_un !== 1'b1 || dout !== exp_dout || count !== 5'd0) begin
            n_fail++;
            $display("FAIL underflow_pulse: un=%b dout=%h count=%0d, want un=1 dout=%h count=0", underflow, dout, count, exp_dout);
        end
        drive(1'b0, 1'b0, 8'h00);
        n_tests++;
        if (underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL underflow_clear: un=%b, want 0", underflow);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b0, 8'h40 + i[7:0]);
            drive(1'b0, 1'b1, 8'h00);
            n_tests++;
            if (dout !== exp_dout) begin
                n_fail++;
                $display("FAIL pre_offset[%0d]: dout=%h, want %h", i, dout, exp_dout);
            end
        end
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'h60 + i[7:0]);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 8'h80 + i[7:0]);
            n_tests++;
            if (count !== 5'd5 || dout !== exp_dout || overflow !== 1'b0 || underflow !== 1'b0) begin
                n_fail++;
                $display("FAIL simul[%0d]: count=%0d dout=%h ov=%b un=%b, want count=5 dout=%h ov=0 un=0",
                         i, count, dout, overflow, underflow, exp_dout);
            end
        end
        n_tests++;
        if (dut.wrop !== m_wp || dut.rdop !== m_rp) begin
            n_fail++;
            $display("FAIL ptr_wrap: wrop=%0d rdop=%0d, want wrop=%0d rdop=%0d", dut.wrop, dut.rdop, m_wp, m_rp);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            n_tests++;
            if (dout !== exp_dout) begin
                n_fail++;
                $display("FAIL simul_drain[%0d]: dout=%h, want %h", i, dout, exp_dout);
            end
        end
    endtask

    task automatic test_collisions();
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 8'hC0 + i[7:0]);
        drive(1'b1, 1'b1, 8'h77);
        n_tests++;
        if (count !== 5'd15 || overflow !== 1'b1 || underflow !== 1'b0 || dout !== exp_dout) begin
            n_fail++;
            $display("FAIL collide_full: count=%0d ov=%b un=%b dout=%h, want count=15 ov=1 un=0 dout=%h",
                     count, overflow, underflow, dout, exp_dout);
        end
        for (int i = 0; i < 15; i++) drive(1'b0, 1'b1, 8'h00);
        n_tests++;
        if (dout !== exp_dout || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL collide_drain: dout=%h empty=%b, want dout=%h empty=1", dout, empty, exp_dout);
        end
        drive(1'b1, 1'b1, 8'h3C);
        n_tests++;
        if (count !== 5'd1 || underflow !== 1'b1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_empty: count=%0d un=%b ov=%b, want count=1 un=1 ov=0", count, underflow, overflow);
        end
        drive(1'b0, 1'b1, 8'h00);
        n_tests++;
        if (dout !== exp_dout || count !== 5'd0) begin
            n_fail++;
            $display("FAIL collide_read: dout=%h count=%0d, want dout=%h count=0", dout, count, exp_dout);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h20 + i[7:0]);
        n_tests++;
        if (count !== 5'd7) begin
            n_fail++;
            $display("FAIL mid_precount: count=%0d, want 7", count);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_clear();
        n_tests++;
        if (count !== 5'd0 || empty !== 1'b1 || dout !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset: count=%0d empty=%b dout=%h, want 0 1 00", count, empty, dout);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, 8'hA5);
`ifdef FIFO_FWFT_EN
        n_tests++;
        if (dout !== 8'hA5) begin
            n_fail++;
            $display("FAIL fwft_visible: dout=%h, want a5", dout);
        end
`endif
        drive(1'b0, 1'b1, 8'h00);
        n_tests++;
        if (dout !== exp_dout || count !== 5'd0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_readback: dout=%h count=%0d empty=%b, want dout=%h count=0 empty=1", dout, count, empty, exp_dout);
        end
`ifndef FIFO_FWFT_EN
        n_tests++;
        if (dout !== 8'hA5) begin
            n_fail++;
            $display("FAIL mid_first_word: dout=%h, want a5", dout);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow_underflow();
        test_back_to_back();
        test_collisions();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised synchronous FIFO. Successor to the fixed 8-bit x 16 FIFO.
- Adds configurable width and depth, programmable almost-full and almost-empty thresholds, an occupancy count output, and overflow/underflow error pulses.
- Sits between a single-clock producer and consumer. It is the DUT bound to the FIFO assertion checker in the bench.

Parameters:
- DATA_W, 8: data width in bits.
- DEPTH, 16: number of entries. Must be a power of 2 and at least 2.
- AF_THRESH, 14: almost_full asserts when count >= AF_THRESH. Legal range 1..DEPTH.
- AE_THRESH, 2: almost_empty asserts when count <= AE_THRESH. Legal range 0..DEPTH-1.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous reset, active-high.
- wr  in  1  write request.
- rd  in  1  read request.
- din  in  DATA_W  write data.
- dout  out  DATA_W  read data.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_empty  out  1  count <= AE_THRESH.
- almost_full  out  1  count >= AF_THRESH.
- count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.

Behaviour:
- Reset is asynchronous, active-high: rst=1 clears immediately, with no clock required.
- Reset values:
  - wrop=0, rdop=0, cnt=0 (pointer and count register names kept so existing checker hierarchy references resolve).
  - dout=0, empty=1, full=0, almost_empty=1, almost_full=0 (with default thresholds), overflow=0, underflow=0.
  - All memory entries cleared to 0, so dout is never X.
- Accept rules, evaluated on the registered state at the posedge:
  - wr_ok = wr & !full.
  - rd_ok = rd & !empty.
- Accepted write: mem[wrop] <= din; wrop <= wrop+1.
- Accepted read: dout <= mem[rdop]; rdop <= rdop+1.
  - Read latency is 1 cycle: data appears on dout the cycle after rd is sampled.
  - dout holds its value on all non-read cycles.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Count update:
  - cnt <= cnt + wr_ok - rd_ok.
  - Both accepted: cnt unchanged.
- Simultaneous wr & rd:
  - When full: the read is accepted. The write is rejected, because full is judged on the pre-edge state. overflow pulses. cnt decrements.
  - When empty: the write is accepted, the read is rejected, and underflow pulses. There is no fall-through in the default mode.
  - Otherwise both are accepted.
- Flags:
  - empty, full, almost_empty and almost_full are combinational decodes of the registered cnt.
  - They therefore update in the same cycle cnt changes, with no extra lag.
- Error pulses:
  - overflow <= wr & full.
  - underflow <= rd & empty.
  - Both are registered and high for exactly one cycle per offending request. The FIFO state is not corrupted.
- Reset mid-operation: all contents and pointers are discarded. The first read after reset release returns the first post-reset write.
- X-safety: no output is X after reset for any legal input sequence.

Optional Feature:
- Macro: FIFO_FWFT_EN, enabling first-word-fall-through mode.
- When defined:
  - dout continuously presents mem[rdop] whenever !empty, and presents 0 when empty.
  - rd acts as a pop acknowledge: the head entry advances, and the next entry is visible in the cycle after the pop.
  - A write into an empty FIFO is visible on dout one cycle after the write edge.
  - All flags, count and error pulses behave exactly as in the default mode.
- When not defined: registered 1-cycle read latency, as described above.

Test Plan:
- Reset check: assert rst asynchronously between edges.
  - Required: empty=1, full=0, count=0 and dout=0 before the next posedge.
- Fill and drain at DEPTH=16, DATA_W=8: write 16 words 0x10..0x1F, then read 16.
  - Required: full=1 after the 16th write; almost_full rises when count reaches 14.
  - Required: dout sequence 0x10..0x1F, each one cycle after its rd; empty=1 after the last read.
- Overflow and underflow:
  - Write to a full FIFO: overflow pulses 1 cycle, count stays 16, contents intact.
  - Read an empty FIFO: underflow pulses 1 cycle, dout unchanged.
- Simultaneous access, starting from count=5 with wr=rd=1 for 10 cycles: count stays 5, read data is in order, and wrop/rdop wrap past 15 correctly.
- Boundary collisions:
  - wr=rd=1 when full: count goes 16->15 and overflow pulses.
  - wr=rd=1 when empty: count goes 0->1 and underflow pulses.
- Reset mid-operation and FWFT mode:
  - rst pulse at count=7: count=0 immediately; the first post-reset write of 0xA5 reads back as 0xA5.
  - FIFO_FWFT_EN defined: dout=0xA5 one cycle after the write edge, with no rd needed.
